// File: rtl/cdic_tick_gen.sv
// Multi-channel fractional tick generator: each channel pulses at clk*NUM/DEN with no drift.
// Optional per-channel 16-bit tick counters are enabled by defining CDIC_TICK_COUNT_EN.

module cdic_tick_ch #(
  parameter int               ACC_W    = 25,
  parameter logic [ACC_W-1:0] INIT_NUM = '0,
  parameter logic [ACC_W-1:0] INIT_DEN = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_num,
  input  logic [ACC_W-1:0] wr_den,
  input  logic             enable,
  output logic             tick
`ifdef CDIC_TICK_COUNT_EN
  ,
  output logic [15:0]      count
`endif
);

  logic [ACC_W-1:0] num, den, acc;
  logic [ACC_W-1:0] acc_nxt, wrap;
  logic [ACC_W:0]   sum;
  logic             tick_nxt;
  logic             clr;

  assign clr = resync | wr;

  // sum is one bit wider so acc+num never overflows; wrap is only used when sum>=den,
  // so it always fits back into ACC_W bits.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, num};
    wrap     = ACC_W'(sum - {1'b0, den});
    acc_nxt  = acc;
    tick_nxt = 1'b0;
    if (clr) begin
      acc_nxt = '0;
    end else if (!enable) begin
      acc_nxt = acc;
    end else if (den == '0) begin
      acc_nxt = '0;
    end else if (num >= den) begin
      acc_nxt  = '0;
      tick_nxt = 1'b1;
    end else if (sum >= {1'b0, den}) begin
      acc_nxt  = wrap;
      tick_nxt = 1'b1;
    end else begin
      acc_nxt = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num  <= INIT_NUM;
      den  <= INIT_DEN;
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      if (wr) begin
        num <= wr_num;
        den <= wr_den;
      end
      acc  <= acc_nxt;
      tick <= tick_nxt;
    end
  end

`ifdef CDIC_TICK_COUNT_EN
  // Counter advances on the same edge the tick register goes high.
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (tick_nxt) count <= count + 16'd1;
  end
`endif

endmodule

module cdic_tick_gen #(
  parameter int                        NUM_CH   = 3,
  parameter int                        ACC_W    = 25,
  parameter logic [NUM_CH*ACC_W-1:0]   INIT_NUM = {25'd44100, 25'd37800, 25'd75},
  parameter logic [NUM_CH*ACC_W-1:0]   INIT_DEN = {3{25'd22226400}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                resync,
  output logic [NUM_CH-1:0]   tick
`ifdef CDIC_TICK_COUNT_EN
  ,
  output logic [NUM_CH*16-1:0] tick_count
`endif
);

  logic [NUM_CH-1:0] wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range cfg_ch matches no channel, so such writes are dropped.
    assign wr[i] = cfg_we && (cfg_ch == 3'(i));

    cdic_tick_ch #(
      .ACC_W    (ACC_W),
      .INIT_NUM (INIT_NUM[i*ACC_W +: ACC_W]),
      .INIT_DEN (INIT_DEN[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .resync (resync),
      .wr     (wr[i]),
      .wr_num (cfg_num),
      .wr_den (cfg_den),
      .enable (ch_enable[i]),
      .tick   (tick[i])
`ifdef CDIC_TICK_COUNT_EN
      ,
      .count  (tick_count[i*16 +: 16])
`endif
    );
  end

endmodule
